altsyncram_dual_port: RTL and testbench
=======================================

Name: altsyncram_dual_port

Overview:
- Synchronous simple-dual-port block RAM with one write port (A) and one registered read port (B).
- Serves as the vendor-style primitive beneath multi-read-port register files and caches; each read port of such a wrapper instantiates one copy.
- Provides a configurable mixed-port read-during-write policy so wrappers can add their own bypass logic.

Parameters:
- OPERATION_MODE, "DUAL_PORT", only supported value; any other value is an elaboration error.
- WIDTH_A, 32, write data width in bits.
- WIDTHAD_A, 10, write address width; depth = 2**WIDTHAD_A words.
- WIDTH_B, 32, read data width; must equal WIDTH_A, otherwise elaboration error.
- WIDTHAD_B, 10, read address width; must equal WIDTHAD_A, otherwise elaboration error.
- READ_DURING_WRITE_MIXED_PORTS, "DONT_CARE", same-address collision policy: "OLD_DATA", "NEW_DATA" or "DONT_CARE".

Ports:
- clk  input  1  sole clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high; clears output register only.
- wren_a  input  1  write enable, port A.
- address_a  input  WIDTHAD_A  write address.
- data_a  input  WIDTH_A  write data.
- q_a  output  WIDTH_A  unused in DUAL_PORT mode; tied to all zeros.
- rden_b  input  1  read enable, port B.
- address_b  input  WIDTHAD_B  read address.
- q_b  output  WIDTH_B  registered read data.

Behaviour:
- Storage: 2**WIDTHAD_A words of WIDTH_A bits.
  - Power-up contents are undefined.
  - Contents are not affected by reset.
- Write: at a rising edge with wren_a=1, mem[address_a] <= data_a. The new value is visible to non-colliding reads starting the following cycle.
- Read latency is 1 cycle:
  - At a rising edge with rden_b=1, q_b <= mem[address_b].
  - q_b is driven directly from a register; there is no combinational path from inputs to q_b.
- rden_b=0: q_b holds its previous value indefinitely.
- reset=1 at a rising edge:
  - q_b <= 0.
  - Reset takes priority over a simultaneous read.
  - A simultaneous write still commits to memory.
- Collision (wren_a=1, rden_b=1, address_a==address_b in the same cycle):
  - "OLD_DATA": q_b gets the pre-write contents.
  - "NEW_DATA": q_b gets data_a.
  - "DONT_CARE": the RTL returns the pre-write contents (deterministic). Verification must not check q_b on this cycle; users must bypass externally.
  - In all modes the memory ends up holding data_a.
- Write to an address different from the read address in the same cycle: no interaction.
- Writes to the same address on consecutive cycles: last write wins.
- Addresses are full-range; there is no out-of-range case.
- q_a is constant 0.

Test Plan:
- Basic write/read: write 0xDEADBEEF @5, then rden_b=1 @5 next cycle -> q_b=0xDEADBEEF one cycle after the read.
- Read hold: read @5 (0xDEADBEEF), then rden_b=0 for 3 cycles while writing 0x12345678 @5 -> q_b stays 0xDEADBEEF throughout; a later read @5 -> 0x12345678.
- Collision:
  - Preload @9=0x11111111, then same-cycle write 0x22222222 @9 with read @9.
  - OLD_DATA -> q_b=0x11111111. NEW_DATA -> q_b=0x22222222. DONT_CARE -> q_b unchecked.
  - In every mode the next read @9 -> 0x22222222.
- Reset: after q_b=0xDEADBEEF, assert reset one cycle together with rden_b=1 @5 -> q_b=0; the next read @5 still returns 0xDEADBEEF, showing memory is intact.
- Back-to-back streaming: write addr i = i*3 for i=0..1023, then read 0..1023 on consecutive cycles -> q_b sequence 0,3,6,… with exactly 1-cycle latency, including wrap at the top address 1023.
- Non-colliding simultaneous: write 0xAAAA0000 @1 while reading @2 (holding 0x0000BBBB) -> q_b=0x0000BBBB; a read @1 on the next cycle -> 0xAAAA0000.

Source files
------------

// File: rtl/altsyncram_dual_port_if.sv
// rtl/altsyncram_dual_port_if.sv - port bundle for the simple dual-port block RAM
//
// Purpose: groups the write port (A) and read port (B) signals of
//          altsyncram_dual_port so wrappers pass one handle per RAM copy.
// Signals:
//    wren_a     write enable, port A
//    address_a  write address, WIDTHAD_A bits
//    data_a     write data, WIDTH_A bits
//    q_a        port A read data (constant zero in DUAL_PORT mode)
//    rden_b     read enable, port B
//    address_b  read address, WIDTHAD_B bits
//    q_b        registered read data, WIDTH_B bits
// Modports:
//    master     the user of the RAM (drives addresses/data, receives q_a/q_b)
//    slave      the RAM itself

interface altsyncram_dual_port_if #(
   parameter int WIDTH_A   = 32,
   parameter int WIDTHAD_A = 10,
   parameter int WIDTH_B   = 32,
   parameter int WIDTHAD_B = 10
);

   logic                 wren_a;
   logic [WIDTHAD_A-1:0] address_a;
   logic [WIDTH_A-1:0]   data_a;
   logic [WIDTH_A-1:0]   q_a;

   logic                 rden_b;
   logic [WIDTHAD_B-1:0] address_b;
   logic [WIDTH_B-1:0]   q_b;

   modport master (
      output wren_a,
      output address_a,
      output data_a,
      input  q_a,
      output rden_b,
      output address_b,
      input  q_b
   );

   modport slave (
      input  wren_a,
      input  address_a,
      input  data_a,
      output q_a,
      input  rden_b,
      input  address_b,
      output q_b
   );

endinterface

// File: rtl/altsyncram_dual_port.sv
// rtl/altsyncram_dual_port.sv - simple dual-port block RAM, one write port, one registered read port
//
// Purpose: vendor-style RAM primitive used beneath multi-read-port register
//          files and caches (one copy per read port). Port A writes, port B
//          reads with one cycle of latency through an output register.
//          The mixed-port read-during-write result is selectable so wrappers
//          can layer their own bypass on top.
// Ports:
//    clk    input   sole clock, rising edge
//    reset  input   synchronous active-high; clears the read register only,
//                   memory contents and in-flight writes are untouched
//    bus    slave   altsyncram_dual_port_if (wren_a/address_a/data_a/q_a,
//                   rden_b/address_b/q_b)
// Parameters:
//    OPERATION_MODE                 only "DUAL_PORT"
//    WIDTH_A / WIDTH_B              data width, must match
//    WIDTHAD_A / WIDTHAD_B          address width, must match; depth 2**WIDTHAD_A
//    READ_DURING_WRITE_MIXED_PORTS  "OLD_DATA", "NEW_DATA" or "DONT_CARE"

module altsyncram_dual_port #(
   parameter string OPERATION_MODE                = "DUAL_PORT",
   parameter int    WIDTH_A                       = 32,
   parameter int    WIDTHAD_A                     = 10,
   parameter int    WIDTH_B                       = 32,
   parameter int    WIDTHAD_B                     = 10,
   parameter string READ_DURING_WRITE_MIXED_PORTS = "DONT_CARE"
) (
   input logic                   clk,
   input logic                   reset,
   altsyncram_dual_port_if.slave bus
);

   localparam int DEPTH = 2 ** WIDTHAD_A;

   // Only NEW_DATA forwards the write data on a collision. DONT_CARE is
   // implemented as OLD_DATA so the output stays deterministic.
   localparam bit FWD_NEW_DATA = (READ_DURING_WRITE_MIXED_PORTS == "NEW_DATA");

   // ------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------
   if (OPERATION_MODE != "DUAL_PORT") begin : g_bad_mode
      $error("altsyncram_dual_port: OPERATION_MODE must be \"DUAL_PORT\"");
   end

   if (WIDTH_B != WIDTH_A) begin : g_bad_width
      $error("altsyncram_dual_port: WIDTH_B must equal WIDTH_A");
   end

   if (WIDTHAD_B != WIDTHAD_A) begin : g_bad_addr_width
      $error("altsyncram_dual_port: WIDTHAD_B must equal WIDTHAD_A");
   end

   if ((READ_DURING_WRITE_MIXED_PORTS != "OLD_DATA") &&
       (READ_DURING_WRITE_MIXED_PORTS != "NEW_DATA") &&
       (READ_DURING_WRITE_MIXED_PORTS != "DONT_CARE")) begin : g_bad_rdw
      $error("altsyncram_dual_port: unknown READ_DURING_WRITE_MIXED_PORTS value");
   end

   // ------------------------------------------------------------------
   // Storage and state
   // ------------------------------------------------------------------
   logic [WIDTH_A-1:0] mem_q [DEPTH];
   logic [WIDTH_B-1:0] q_b_q;
   logic [WIDTH_B-1:0] q_b_d;
   logic               collide;

   // Same-cycle write and read of one address.
   assign collide = bus.wren_a && bus.rden_b && (bus.address_a == bus.address_b);

   // ------------------------------------------------------------------
   // Write port A. No reset: contents survive reset, and a write issued
   // alongside reset still commits.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (bus.wren_a) begin
         mem_q[bus.address_a] <= bus.data_a;
      end
   end

   // ------------------------------------------------------------------
   // Read port B next-state. mem_q is sampled before this edge's write
   // lands, so the array read already yields old data on a collision.
   // ------------------------------------------------------------------
   always_comb begin
      q_b_d = q_b_q;
      if (bus.rden_b) begin
         if (FWD_NEW_DATA && collide) begin
            q_b_d = bus.data_a;
         end else begin
            q_b_d = mem_q[bus.address_b];
         end
      end
   end

   // Output register; reset wins over a simultaneous read.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_b_q <= '0;
      end else begin
         q_b_q <= q_b_d;
      end
   end

   assign bus.q_b = q_b_q;
   assign bus.q_a = '0;

endmodule

// File: tb/tb_altsyncram_dual_port.sv
// tb/tb_altsyncram_dual_port.sv - directed bench for altsyncram_dual_port in all three collision modes

module tb_altsyncram_dual_port;

   localparam int W  = 32;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          wren_a;
   logic [AW-1:0] address_a;
   logic [W-1:0]  data_a;
   logic          rden_b;
   logic [AW-1:0] address_b;

   int test_cnt = 0;
   int fail_cnt = 0;

   always #5 clk = ~clk;

   altsyncram_dual_port_if #(.WIDTH_A(W), .WIDTHAD_A(AW), .WIDTH_B(W), .WIDTHAD_B(AW)) bus_old ();
   altsyncram_dual_port_if #(.WIDTH_A(W), .WIDTHAD_A(AW), .WIDTH_B(W), .WIDTHAD_B(AW)) bus_new ();
   altsyncram_dual_port_if #(.WIDTH_A(W), .WIDTHAD_A(AW), .WIDTH_B(W), .WIDTHAD_B(AW)) bus_dc ();

   assign bus_old.wren_a    = wren_a;
   assign bus_old.address_a = address_a;
   assign bus_old.data_a    = data_a;
   assign bus_old.rden_b    = rden_b;
   assign bus_old.address_b = address_b;
   assign bus_new.wren_a    = wren_a;
   assign bus_new.address_a = address_a;
   assign bus_new.data_a    = data_a;
   assign bus_new.rden_b    = rden_b;
   assign bus_new.address_b = address_b;
   assign bus_dc.wren_a     = wren_a;
   assign bus_dc.address_a  = address_a;
   assign bus_dc.data_a     = data_a;
   assign bus_dc.rden_b     = rden_b;
   assign bus_dc.address_b  = address_b;

   altsyncram_dual_port #(
      .OPERATION_MODE("DUAL_PORT"), .WIDTH_A(W), .WIDTHAD_A(AW), .WIDTH_B(W), .WIDTHAD_B(AW),
      .READ_DURING_WRITE_MIXED_PORTS("OLD_DATA")
   ) u_old (.clk(clk), .reset(reset), .bus(bus_old));

   altsyncram_dual_port #(
      .OPERATION_MODE("DUAL_PORT"), .WIDTH_A(W), .WIDTHAD_A(AW), .WIDTH_B(W), .WIDTHAD_B(AW),
      .READ_DURING_WRITE_MIXED_PORTS("NEW_DATA")
   ) u_new (.clk(clk), .reset(reset), .bus(bus_new));

   altsyncram_dual_port #(
      .OPERATION_MODE("DUAL_PORT"), .WIDTH_A(W), .WIDTHAD_A(AW), .WIDTH_B(W), .WIDTHAD_B(AW),
      .READ_DURING_WRITE_MIXED_PORTS("DONT_CARE")
   ) u_dc (.clk(clk), .reset(reset), .bus(bus_dc));

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      test_cnt++;
      assert (obs === exp)
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   // q_b of all three copies; skip_dc leaves the DONT_CARE copy unchecked.
   task automatic chk_all(input string tag, input logic [W-1:0] exp, input bit skip_dc);
      chk({tag, "/old"}, bus_old.q_b, exp);
      chk({tag, "/new"}, bus_new.q_b, exp);
      if (!skip_dc) chk({tag, "/dc"}, bus_dc.q_b, exp);
   endtask

   task automatic chk_qa(input string tag);
      chk({tag, "/qa_old"}, bus_old.q_a, '0);
      chk({tag, "/qa_new"}, bus_new.q_a, '0);
      chk({tag, "/qa_dc"},  bus_dc.q_a,  '0);
   endtask

   // Apply one cycle of stimulus, clock it, and leave outputs settled 1 time unit after the edge.
   task automatic cyc(input bit rst, input bit w, input int wa, input logic [W-1:0] wd,
                      input bit r, input int ra);
      reset     = rst;
      wren_a    = w;
      address_a = AW'(wa);
      data_a    = wd;
      rden_b    = r;
      address_b = AW'(ra);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(0, 0, 0, '0, 0, 0);
   endtask

   initial begin
      reset = 1'b0; wren_a = 1'b0; address_a = '0; data_a = '0; rden_b = 1'b0; address_b = '0;
      #2;

      // Reset state
      cyc(1, 0, 0, '0, 0, 0);
      chk_all("reset_state", 32'h0, 0);
      chk_qa("reset_state");

      // Basic write then read, with exact one-cycle latency
      cyc(0, 1, 5, 32'hDEADBEEF, 0, 0);
      chk_all("after_write_no_read", 32'h0, 0);
      cyc(0, 0, 0, '0, 1, 5);
      chk_all("basic_read", 32'hDEADBEEF, 0);

      // Reset alongside a read: reset wins, memory intact
      cyc(1, 0, 0, '0, 1, 5);
      chk_all("reset_over_read", 32'h0, 0);
      cyc(0, 0, 0, '0, 1, 5);
      chk_all("read_after_reset", 32'hDEADBEEF, 0);

      // Read hold while the location is rewritten
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 5, 32'h12345678, 0, 5);
         chk_all($sformatf("hold_%0d", i), 32'hDEADBEEF, 0);
      end
      cyc(0, 0, 0, '0, 1, 5);
      chk_all("read_after_hold", 32'h12345678, 0);

      // Collision: OLD_DATA returns pre-write, NEW_DATA returns written data
      cyc(0, 1, 9, 32'h11111111, 0, 0);
      cyc(0, 1, 9, 32'h22222222, 1, 9);
      chk("collide/old", bus_old.q_b, 32'h11111111);
      chk("collide/new", bus_new.q_b, 32'h22222222);
      cyc(0, 0, 0, '0, 1, 9);
      chk_all("after_collide", 32'h22222222, 0);

      // Write committed during reset
      cyc(1, 1, 7, 32'h5A5A5A5A, 1, 7);
      chk_all("reset_with_write", 32'h0, 0);
      cyc(0, 0, 0, '0, 1, 7);
      chk_all("write_during_reset", 32'h5A5A5A5A, 0);

      // Non-colliding simultaneous write and read
      cyc(0, 1, 2, 32'h0000BBBB, 0, 0);
      cyc(0, 1, 1, 32'hAAAA0000, 1, 2);
      chk_all("noncollide_read", 32'h0000BBBB, 0);
      cyc(0, 0, 0, '0, 1, 1);
      chk_all("noncollide_written", 32'hAAAA0000, 0);

      // Back-to-back writes to one address: last wins
      cyc(0, 1, 3, 32'h00000001, 0, 0);
      cyc(0, 1, 3, 32'h00000002, 0, 0);
      cyc(0, 0, 0, '0, 1, 3);
      chk_all("last_write_wins", 32'h00000002, 0);
      chk_qa("mid_run");

      // Streaming: fill then read every address back-to-back, wrapping to 0
      for (int i = 0; i < 1024; i++) begin
         cyc(0, 1, i, W'(i * 3), 0, 0);
      end
      for (int i = 0; i <= 1024; i++) begin
         cyc(0, 0, 0, '0, 1, i % 1024);
         chk_all($sformatf("stream_%0d", i % 1024), W'((i % 1024) * 3), 0);
      end
      idle();
      chk_all("stream_hold", 32'h0, 0);
      chk_qa("end");

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
